ioctl_sink: RTL and testbench
=============================

// Module: ioctl_sink
// PURPOSE
//  Receiving end of the HPS ioctl download stream in emu: takes bytes from hps_io (ioctl_wr/addr/dout) and returns ioctl_wait.
//  Bytes go to a small FIFO. They drain to the SDRAM VFD-image region (addr < IMG_BYTES) or the ucom43 ROM-init port (next ROM_BYTES).
//  Back-pressures the HPS so SDRAM refresh/arbitration never loses a byte; reports completion, checksum and sticky errors.
// PARAMETERS
//  IMG_BYTES   614400  bytes of VFD background image (2*640*480) routed to SDRAM
//  ROM_BYTES   4096    bytes routed to ucom43 rom_init port after the image
//  FIFO_DEPTH  4       entries (addr+data), power of two, >=4
//  ACK_TIMEOUT 63      max cycles to wait for sdram_ack before abandoning a write
// PORTS
//  clk_sys        in   1   system clock (100 MHz)
//  reset          in   1   async, active-high
//  ioctl_download in   1   download in progress (level)
//  ioctl_wr       in   1   one-cycle byte strobe
//  ioctl_addr     in   25  byte address
//  ioctl_dout     in   8   byte data
//  ioctl_wait     out  1   back-pressure to hps_io
//  sdram_addr     out  25  write address
//  sdram_din      out  8   write data
//  sdram_we       out  1   one-cycle write request
//  sdram_ack      in   1   one-cycle write-complete pulse from sdram
//  rom_we         out  1   one-cycle ROM write strobe
//  rom_addr       out  12  ROM byte address (ioctl_addr - IMG_BYTES)
//  rom_data       out  8   ROM byte
//  done           out  1   level: last download fully committed
//  checksum       out  8   mod-256 sum of all accepted bytes
//  err            out  3   sticky {timeout, range, overflow}
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; FSM IDLE. Reset mid-download discards FIFO contents, no further strobes.
//  Rising edge of ioctl_download: clear done, checksum, err, FIFO (same cycle; a coincident ioctl_wr is accepted after the clear).
//  Accept: ioctl_wr with FIFO not full -> push {addr,data}; checksum += data next cycle.
//  Overflow: ioctl_wr with FIFO full -> byte dropped, err[0]=1, checksum unchanged.
//  ioctl_wait: registered; goes 1 the cycle after count >= FIFO_DEPTH-1; goes 0 after count <= 1 (hysteresis). Also 1 while FSM in WAIT_ACK with count>=FIFO_DEPTH-1.
//  Simultaneous push and pop: count unchanged; both take effect.
//  Drain FSM (registered outputs):
//   IDLE     : FIFO non-empty -> pop head, decode -> SDRAM / ROM / DROP.
//   SDRAM    : sdram_we=1, sdram_addr/din = entry, 1 cycle -> WAIT_ACK.
//   WAIT_ACK : sdram_ack -> IDLE; timer hits ACK_TIMEOUT -> err[2]=1, IDLE. Ack in the same cycle as timeout counts as success.
//   ROM      : rom_we=1, rom_addr = addr-IMG_BYTES (12 bits), 1 cycle -> IDLE (no ack).
//   DROP     : addr >= IMG_BYTES+ROM_BYTES -> err[1]=1, no strobe, -> IDLE.
//  Throughput: ROM bytes 1 per 2 cycles; SDRAM bytes 1 per (3+ack latency) cycles.
//  done: set the cycle after ioctl_download=0 AND FIFO empty AND FSM IDLE; held until the next download rises.
//  sdram_ack outside WAIT_ACK is ignored. ioctl_wr with ioctl_download=0 is ignored.
//  Address compare uses full 25-bit unsigned; ROM offset truncates to 12 bits.
// STRUCTURE
//  Package ioctl_sink_pkg: enum sink_state_t {IDLE,SDRAM,WAIT_ACK,ROM,DROP}; typedef struct {logic[24:0] addr; logic[7:0] data;} ioctl_beat_t;
//   err bit index constants ERR_OVF=0, ERR_RANGE=1, ERR_TMO=2.
//  Sub-module sink_fifo: sync FIFO of ioctl_beat_t, FIFO_DEPTH entries, ports push/pop/full/empty/count. Async reset plus sync clear.
//  Top keeps the FSM, wait hysteresis, checksum, done and err logic.
// TESTING
//  1 Write 4 bytes 0x11,0x22,0x33,0x44 at addr 0..3, ack 2 cycles after each we -> 4 sdram_we at addr 0..3; checksum=0xAA; done=1 after download falls.
//  2 Bytes at 614400,614401 = 0xC0,0xDE -> rom_we at rom_addr 0,1 with data C0,DE; no sdram_we.
//  3 Hold sdram_ack low, write every cycle -> ioctl_wait=1 once 3 entries queued; after 64 cycles err=3'b100; FSM recovers.
//  4 Ignore ioctl_wait, write 6 back-to-back with no ack -> err[0]=1; checksum excludes dropped bytes.
//  5 Byte at addr 618496 -> err=3'b010, no strobes; then new download rise -> err=0, done=0, checksum=0.
//  6 Assert reset with 3 entries queued -> all outputs 0 next cycle; no strobes after release.

Source files
------------

// File: rtl/ioctl_sink_pkg.sv
// Shared types and constants for the HPS ioctl download sink.
package ioctl_sink_pkg;

  localparam int IMG_BYTES_DEF   = 614400;
  localparam int ROM_BYTES_DEF   = 4096;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int ACK_TIMEOUT_DEF = 63;

  localparam int ERR_OVF   = 0;
  localparam int ERR_RANGE = 1;
  localparam int ERR_TMO   = 2;

  typedef enum logic [2:0] {
    IDLE,
    SDRAM,
    WAIT_ACK,
    ROM,
    DROP
  } sink_state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } ioctl_beat_t;

endpackage

// File: rtl/ioctl_sink_fifo.sv
// Small synchronous FIFO of {addr,data} beats; a sync clear may coincide with a push,
// in which case the pushed beat becomes the only entry.
module sink_fifo
  import ioctl_sink_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  ioctl_beat_t   din,
  output ioctl_beat_t   dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  ioctl_beat_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;
  logic [AW-1:0] wr_idx;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push & (clr | ~full);
  assign pop_ok  = pop & ~empty & ~clr;
  assign wr_idx  = clr ? '0 : wr_ptr_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_idx] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= push_ok ? AW'(1) : '0;
      rd_ptr_q <= '0;
      count_q  <= push_ok ? CW'(1) : '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/ioctl_sink.sv
// Receiving end of the HPS ioctl download: buffers bytes, drains them to SDRAM or the
// ucom43 ROM-init port, and reports back-pressure, completion, checksum and sticky errors.
module ioctl_sink
  import ioctl_sink_pkg::*;
#(
  parameter int IMG_BYTES   = IMG_BYTES_DEF,
  parameter int ROM_BYTES   = ROM_BYTES_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [24:0] sdram_addr,
  output logic [7:0]  sdram_din,
  output logic        sdram_we,
  input  logic        sdram_ack,
  output logic        rom_we,
  output logic [11:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        done,
  output logic [7:0]  checksum,
  output logic [2:0]  err,
  output sink_state_t dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [24:0] IMG_END = 25'(IMG_BYTES);
  localparam logic [24:0] ROM_END = 25'(IMG_BYTES + ROM_BYTES);
  localparam logic [11:0] IMG_LO  = 12'(IMG_BYTES);

  sink_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dl_q, armed_q, armed_d, done_q, done_d, wait_q, wait_d;
  logic [7:0]    checksum_q, checksum_d;
  logic [2:0]    err_q, err_d, err_set;
  logic          sdram_we_q, sdram_we_d, rom_we_q, rom_we_d;
  logic [24:0]   sdram_addr_q, sdram_addr_d;
  logic [7:0]    sdram_din_q, sdram_din_d, rom_data_q, rom_data_d;
  logic [11:0]   rom_addr_q, rom_addr_d;

  logic          dl_rise, wr_ok, push, pop, ovf, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  ioctl_beat_t   head;

  assign dl_rise = ioctl_download & ~dl_q;
  assign wr_ok   = ioctl_wr & ioctl_download;
  assign push    = wr_ok & (dl_rise | ~fifo_full);
  assign ovf     = wr_ok & ~dl_rise & fifo_full;

  sink_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .clr   (dl_rise),
    .push  (push),
    .pop   (pop),
    .din   ({ioctl_addr, ioctl_dout}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Drain FSM; strobes and write payload are registered so they align with the state.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    pop          = 1'b0;
    err_set      = '0;
    sdram_addr_d = sdram_addr_q;
    sdram_din_d  = sdram_din_q;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    err_set[ERR_OVF] = ovf;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !dl_rise) begin
          pop = 1'b1;
          if (head.addr < IMG_END) begin
            state_d      = SDRAM;
            sdram_addr_d = head.addr;
            sdram_din_d  = head.data;
          end else if (head.addr < ROM_END) begin
            state_d    = ROM;
            rom_addr_d = head.addr[11:0] - IMG_LO;
            rom_data_d = head.data;
          end else begin
            state_d = DROP;
          end
        end
      end
      SDRAM: begin
        state_d = WAIT_ACK;
        timer_d = '0;
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          state_d = IDLE;
        end else if (timer_q == TW'(ACK_TIMEOUT)) begin
          state_d          = IDLE;
          err_set[ERR_TMO] = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ROM:  state_d = IDLE;
      DROP: begin
        state_d            = IDLE;
        err_set[ERR_RANGE] = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    sdram_we_d = (state_d == SDRAM);
    rom_we_d   = (state_d == ROM);
  end

  // Status: checksum, sticky errors, done tracking and wait hysteresis.
  always_comb begin
    checksum_d = (dl_rise ? 8'd0 : checksum_q) + (push ? ioctl_dout : 8'd0);
    err_d      = (dl_rise ? 3'd0 : err_q) | err_set;
    armed_d    = armed_q;
    done_d     = done_q;
    wait_d     = wait_q;
    if (dl_rise) begin
      armed_d = 1'b1;
      done_d  = 1'b0;
    end else if (armed_q && !ioctl_download && fifo_empty && state_q == IDLE) begin
      armed_d = 1'b0;
      done_d  = 1'b1;
    end
    if (fifo_count >= CW'(FIFO_DEPTH - 1)) wait_d = 1'b1;
    else if (fifo_count <= CW'(1))         wait_d = 1'b0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      dl_q         <= 1'b0;
      armed_q      <= 1'b0;
      done_q       <= 1'b0;
      wait_q       <= 1'b0;
      checksum_q   <= '0;
      err_q        <= '0;
      sdram_we_q   <= 1'b0;
      rom_we_q     <= 1'b0;
      sdram_addr_q <= '0;
      sdram_din_q  <= '0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      dl_q         <= ioctl_download;
      armed_q      <= armed_d;
      done_q       <= done_d;
      wait_q       <= wait_d;
      checksum_q   <= checksum_d;
      err_q        <= err_d;
      sdram_we_q   <= sdram_we_d;
      rom_we_q     <= rom_we_d;
      sdram_addr_q <= sdram_addr_d;
      sdram_din_q  <= sdram_din_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign sdram_addr = sdram_addr_q;
  assign sdram_din  = sdram_din_q;
  assign sdram_we   = sdram_we_q;
  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign done       = done_q;
  assign checksum   = checksum_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ioctl_sink.sv
// Directed bench for ioctl_sink: SDRAM/ROM routing, back-pressure, timeout, overflow,
// range drop, download restart and mid-download reset.
module tb_ioctl_sink;
  import ioctl_sink_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_din;
  logic        sdram_we;
  logic        sdram_ack;
  logic        rom_we;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic        done;
  logic [7:0]  checksum;
  logic [2:0]  err;
  sink_state_t dbg_state;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [32:0] exp_q[$];
  logic [32:0] sd_log[$];
  logic [19:0] exp_rom_q[$];
  logic [19:0] rom_log[$];
  bit          ack_en = 1'b1;
  int          ack_dly = 0;
  int          cyc;

  ioctl_sink dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_we(sdram_we), .sdram_ack(sdram_ack),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data), .done(done),
    .checksum(checksum), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  // SDRAM model: ack two cycles after each write request when enabled
  always @(negedge clk_sys) begin
    sdram_ack = ack_en && (ack_dly == 1);
    if (ack_dly != 0) ack_dly = ack_dly - 1;
    if (sdram_we) ack_dly = 2;
  end

  // strobe monitor
  always @(negedge clk_sys) begin
    if (sdram_we) sd_log.push_back({sdram_addr, sdram_din});
    if (rom_we)   rom_log.push_back({rom_addr, rom_data});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit obey);
    int guard = 0;
    if (obey) begin
      while (ioctl_wait && guard < 500) begin
        @(negedge clk_sys);
        guard++;
      end
      if (guard >= 500) chk("wait_bound", 64'(guard), 64'd0);
    end
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_dl(input string tag);
    int guard = 0;
    ioctl_download = 1'b0;
    while (!done && guard < 1000) begin
      @(negedge clk_sys);
      guard++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic check_logs(input string tag);
    chk({tag, "_sd_n"}, 64'(sd_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < sd_log.size(); i++)
      chk({tag, "_sd"}, 64'(sd_log[i]), 64'(exp_q[i]));
    chk({tag, "_rom_n"}, 64'(rom_log.size()), 64'(exp_rom_q.size()));
    for (int i = 0; i < exp_rom_q.size() && i < rom_log.size(); i++)
      chk({tag, "_rom"}, 64'(rom_log[i]), 64'(exp_rom_q[i]));
    exp_q.delete(); sd_log.delete(); exp_rom_q.delete(); rom_log.delete();
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    sdram_ack = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_sd",  64'({sdram_addr, sdram_din, sdram_we}), 64'd0);
    chk("rst_rom", 64'({rom_addr, rom_data, rom_we}), 64'd0);
    chk("rst_sts", 64'({ioctl_wait, done, checksum, err}), 64'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // 1: four image bytes to SDRAM
    start_dl();
    wr_byte(25'd0, 8'h11, 1'b1); wr_byte(25'd1, 8'h22, 1'b1);
    wr_byte(25'd2, 8'h33, 1'b1); wr_byte(25'd3, 8'h44, 1'b1);
    end_dl("t1");
    chk("t1_csum", 64'(checksum), 64'hAA);
    chk("t1_err", 64'(err), 64'd0);
    exp_q.push_back({25'd0, 8'h11}); exp_q.push_back({25'd1, 8'h22});
    exp_q.push_back({25'd2, 8'h33}); exp_q.push_back({25'd3, 8'h44});
    check_logs("t1");

    // 2: two bytes into the ROM window
    start_dl();
    chk("t2_done_clr", 64'(done), 64'd0);
    wr_byte(25'd614400, 8'hC0, 1'b1); wr_byte(25'd614401, 8'hDE, 1'b1);
    end_dl("t2");
    chk("t2_csum", 64'(checksum), 64'h9E);
    exp_rom_q.push_back({12'd0, 8'hC0}); exp_rom_q.push_back({12'd1, 8'hDE});
    check_logs("t2");

    // 3: no ack -> back-pressure, then timeout and recovery
    ack_en = 1'b0;
    start_dl();
    for (int i = 0; i < 5; i++) wr_byte(25'(16 + i), 8'(8'hA0 + i), 1'b1);
    chk("t3_wait", 64'(ioctl_wait), 64'd1);
    cyc = 0;
    while (!err[ERR_TMO] && cyc < 200) begin
      @(negedge clk_sys);
      cyc++;
    end
    chk("t3_tmo_err", 64'(err), 64'b100);
    chk("t3_tmo_not_early", 64'(cyc >= 50), 64'd1);
    ack_en = 1'b1;
    end_dl("t3");
    chk("t3_wait_rel", 64'(ioctl_wait), 64'd0);
    chk("t3_err_final", 64'(err), 64'b100);
    chk("t3_csum", 64'(checksum), 64'h2A);
    for (int i = 0; i < 5; i++) exp_q.push_back({25'(16 + i), 8'(8'hA0 + i)});
    check_logs("t3");

    // 4: ignore wait, six back-to-back bytes without ack -> one dropped
    ack_en = 1'b0;
    start_dl();
    chk("t4_err_clr", 64'(err), 64'd0);
    for (int i = 0; i < 6; i++) wr_byte(25'(32 + i), 8'(i + 1), 1'b0);
    chk("t4_ovf", 64'(err), 64'b001);
    chk("t4_csum", 64'(checksum), 64'h0F);
    ack_en = 1'b1;
    end_dl("t4");
    chk("t4_err_final", 64'(err), 64'b101);
    for (int i = 0; i < 5; i++) exp_q.push_back({25'(32 + i), 8'(i + 1)});
    check_logs("t4");

    // 5: out-of-range byte, then a fresh download clears status
    start_dl();
    wr_byte(25'd618496, 8'h5A, 1'b1);
    end_dl("t5");
    chk("t5_err", 64'(err), 64'b010);
    chk("t5_csum", 64'(checksum), 64'h5A);
    check_logs("t5");
    start_dl();
    chk("t5_clr", 64'({done, checksum, err}), 64'd0);

    // 6: reset with entries queued
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) wr_byte(25'(64 + i), 8'(8'h70 + i), 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("t6_async_sd", 64'({sdram_addr, sdram_din, sdram_we}), 64'd0);
    @(negedge clk_sys);
    chk("t6_sd",  64'({sdram_addr, sdram_din, sdram_we}), 64'd0);
    chk("t6_rom", 64'({rom_addr, rom_data, rom_we}), 64'd0);
    chk("t6_sts", 64'({ioctl_wait, done, checksum, err}), 64'd0);
    reset = 1'b0;
    sd_log.delete(); rom_log.delete(); exp_q.delete(); exp_rom_q.delete();
    ack_en = 1'b1;
    repeat (20) @(negedge clk_sys);
    check_logs("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
